// File: rtl/mult_share_arb.sv
// Purpose  : round-robin scheduler sharing one W x W multiplier among NREQ requesters.
// Latency  : accept -> rsp_valid in 2 cycles (3 with MULT_SHARE_PIPE_EN for a registered multiplier).
// Backpres.: rsp_ready=0 holds the response and all outputs; no new grant until it is consumed.
// Macro    : MULT_SHARE_PIPE_EN adds the WAIT state (mul_c sampled two edges after accept).
// Ports    : clk, rst (async, active-high)
//            req_valid/req_ready[NREQ]  per-requester handshake, req_ready is a one-hot grant
//            req_a/req_b[NREQ*W]        operands, requester i at [i*W +: W]
//            mul_a/mul_b[W] -> multiplier, mul_c[2W] <- multiplier product
//            rsp_valid/rsp_ready, rsp_id[IDW], rsp_prod[2W]  tagged response
module mult_share_arb #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic [2*W-1:0]    mul_c,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [2*W-1:0]    rsp_prod
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
`ifdef MULT_SHARE_PIPE_EN
        WAIT = 2'd3,
`endif
        RESP = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] tag;
    logic [IDW-1:0] win;
    logic           found;
    logic           grant;

    // Winner: first valid requester scanning ptr, ptr+1, ... modulo NREQ.
    always_comb begin : pick_winner
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    // No grant is offered while reset is held, so no handshake can be
    // claimed by a requester on an edge the block ignores.
    assign grant = (state == IDLE) && found && !rst;

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[win] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant) begin
`ifdef MULT_SHARE_PIPE_EN
                    state_nxt = WAIT;
`else
                    state_nxt = CAPT;
`endif
                end
            end
`ifdef MULT_SHARE_PIPE_EN
            // Registered multiplier: its output reflects mul_a/mul_b one edge later.
            WAIT:    state_nxt = CAPT;
`endif
            CAPT:    state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath. mul_a/mul_b and the response fields keep their last values
    // after the handshake; only a new grant or capture overwrites them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            tag       <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_prod  <= '0;
        end else begin
            if (grant) begin
                mul_a <= req_a[int'(win)*W +: W];
                mul_b <= req_b[int'(win)*W +: W];
                tag   <= win;
                if (int'(win) == NREQ - 1) begin
                    ptr <= '0;
                end else begin
                    ptr <= win + 1'b1;
                end
            end
            if (state == CAPT) begin
                rsp_prod  <= mul_c;
                rsp_id    <= tag;
                rsp_valid <= 1'b1;
            end
            if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb (NREQ=4, W=4) with a behavioural multiplier.
// Latency: follows MULT_SHARE_PIPE_EN (registered multiplier model when defined).
// Backpressure: exercised by holding rsp_ready low in RESP.
module tb_mult_share_arb;

`ifdef MULT_SHARE_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic [7:0]  mul_c;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_prod;

    int pass_cnt;
    int total_cnt;

    logic [7:0] prod_tab [4] = '{8'h02, 8'h0C, 8'hE1, 8'h36};

    mult_share_arb #(.NREQ(4), .W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_c     (mul_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod)
    );

`ifdef MULT_SHARE_PIPE_EN
    logic [7:0] mul_q;
    always @(posedge clk) mul_q <= {4'b0, mul_a} * {4'b0, mul_b};
    assign mul_c = mul_q;
`else
    assign mul_c = {4'b0, mul_a} * {4'b0, mul_b};
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 2-3 time units after the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        step();
        step();
        #1;
        total_cnt++; if (req_ready !== 4'b0000) $display("FAIL rst_req_ready: got %b want 0000", req_ready); else pass_cnt++;
        total_cnt++; if (mul_a !== 4'h0) $display("FAIL rst_mul_a: got %h want 0", mul_a); else pass_cnt++;
        total_cnt++; if (mul_b !== 4'h0) $display("FAIL rst_mul_b: got %h want 0", mul_b); else pass_cnt++;
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); else pass_cnt++;
        total_cnt++; if (rsp_id !== 2'd0) $display("FAIL rst_rsp_id: got %0d want 0", rsp_id); else pass_cnt++;
        total_cnt++; if (rsp_prod !== 8'h00) $display("FAIL rst_rsp_prod: got %h want 00", rsp_prod); else pass_cnt++;
        rst = 1'b0;
        step();
        step();
        #1;
        total_cnt++; if (req_ready !== 4'b0000) $display("FAIL rel_req_ready: got %b want 0000", req_ready); else pass_cnt++;
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rel_rsp_valid: got %b want 0", rsp_valid); else pass_cnt++;
    endtask

    task automatic test_single();
        req_a[11:8] = 4'd5;
        req_b[11:8] = 4'd3;
        req_valid = 4'b0100;
        #1;
        total_cnt++; if (req_ready !== 4'b0100) $display("FAIL single_grant: got %b want 0100", req_ready); else pass_cnt++;
        step();
        req_valid = 4'b0000;
        #1;
        total_cnt++; if (req_ready !== 4'b0000) $display("FAIL single_busy_ready: got %b want 0000", req_ready); else pass_cnt++;
        total_cnt++; if (mul_a !== 4'd5) $display("FAIL single_mul_a: got %0d want 5", mul_a); else pass_cnt++;
        total_cnt++; if (mul_b !== 4'd3) $display("FAIL single_mul_b: got %0d want 3", mul_b); else pass_cnt++;
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL single_early_valid: got %b want 0", rsp_valid); else pass_cnt++;
        repeat (LAT - 1) step();
        #1;
        total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); else pass_cnt++;
        total_cnt++; if (rsp_id !== 2'd2) $display("FAIL single_rsp_id: got %0d want 2", rsp_id); else pass_cnt++;
        total_cnt++; if (rsp_prod !== 8'h0F) $display("FAIL single_rsp_prod: got %h want 0f", rsp_prod); else pass_cnt++;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        #1;
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL single_rsp_drop: got %b want 0", rsp_valid); else pass_cnt++;
        total_cnt++; if (rsp_prod !== 8'h0F) $display("FAIL single_keep_prod: got %h want 0f", rsp_prod); else pass_cnt++;
        total_cnt++; if (rsp_id !== 2'd2) $display("FAIL single_keep_id: got %0d want 2", rsp_id); else pass_cnt++;
        total_cnt++; if (mul_a !== 4'd5) $display("FAIL single_keep_mul_a: got %0d want 5", mul_a); else pass_cnt++;
        req_a[11:8] = 4'd15;
        req_b[11:8] = 4'd15;
    endtask

    // ptr is 3 after the single grant to requester 2.
    task automatic test_wrap();
        rsp_ready = 1'b1;
        req_valid = 4'b1010;
        #1;
        total_cnt++; if (req_ready !== 4'b1000) $display("FAIL wrap_grant3: got %b want 1000", req_ready); else pass_cnt++;
        step();
        #1;
        total_cnt++; if (mul_a !== 4'd9) $display("FAIL wrap_mul_a: got %0d want 9", mul_a); else pass_cnt++;
        total_cnt++; if (mul_b !== 4'd6) $display("FAIL wrap_mul_b: got %0d want 6", mul_b); else pass_cnt++;
        repeat (LAT - 1) step();
        #1;
        total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL wrap_rsp_valid: got %b want 1", rsp_valid); else pass_cnt++;
        total_cnt++; if (rsp_id !== 2'd3) $display("FAIL wrap_rsp_id: got %0d want 3", rsp_id); else pass_cnt++;
        total_cnt++; if (rsp_prod !== 8'h36) $display("FAIL wrap_rsp_prod: got %h want 36", rsp_prod); else pass_cnt++;
        step();
        #1;
        total_cnt++; if (req_ready !== 4'b0010) $display("FAIL wrap_grant1: got %b want 0010", req_ready); else pass_cnt++;
    endtask

    // Entered in IDLE with requester 1 being granted; ptr becomes 2.
    task automatic test_backpressure();
        rsp_ready = 1'b0;
        step();
        req_valid = 4'b0100;
        repeat (LAT - 1) step();
        #1;
        total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL bp_rsp_valid: got %b want 1", rsp_valid); else pass_cnt++;
        total_cnt++; if (rsp_id !== 2'd1) $display("FAIL bp_rsp_id: got %0d want 1", rsp_id); else pass_cnt++;
        total_cnt++; if (rsp_prod !== 8'h0C) $display("FAIL bp_rsp_prod: got %h want 0c", rsp_prod); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            step();
            #1;
            total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, rsp_valid); else pass_cnt++;
            total_cnt++; if (rsp_id !== 2'd1) $display("FAIL bp_hold_id[%0d]: got %0d want 1", i, rsp_id); else pass_cnt++;
            total_cnt++; if (rsp_prod !== 8'h0C) $display("FAIL bp_hold_prod[%0d]: got %h want 0c", i, rsp_prod); else pass_cnt++;
            total_cnt++; if (req_ready !== 4'b0000) $display("FAIL bp_hold_ready[%0d]: got %b want 0000", i, req_ready); else pass_cnt++;
        end
        // Requester 2 withdraws before it could be granted.
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        #1;
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL bp_release: got %b want 0", rsp_valid); else pass_cnt++;
        step();
        #1;
        total_cnt++; if (req_ready !== 4'b0000) $display("FAIL drop_no_grant: got %b want 0000", req_ready); else pass_cnt++;
        total_cnt++; if (mul_a !== 4'd3) $display("FAIL drop_mul_a_kept: got %0d want 3", mul_a); else pass_cnt++;
    endtask

    // ptr is 2 here, so the lone requester 0 wins after scanning 2,3,0.
    task automatic test_reset_mid_resp();
        req_a[3:0] = 4'd7;
        req_b[3:0] = 4'd9;
        req_valid  = 4'b0001;
        #1;
        total_cnt++; if (req_ready !== 4'b0001) $display("FAIL mid_grant0: got %b want 0001", req_ready); else pass_cnt++;
        step();
        req_valid = 4'b0000;
        repeat (LAT - 1) step();
        #1;
        total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL mid_rsp_valid: got %b want 1", rsp_valid); else pass_cnt++;
        total_cnt++; if (rsp_prod !== 8'h3F) $display("FAIL mid_rsp_prod: got %h want 3f", rsp_prod); else pass_cnt++;
        #2;
        req_valid = 4'b1111;
        rst = 1'b1;
        #1;
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL async_rsp_valid: got %b want 0", rsp_valid); else pass_cnt++;
        total_cnt++; if (rsp_prod !== 8'h00) $display("FAIL async_rsp_prod: got %h want 00", rsp_prod); else pass_cnt++;
        total_cnt++; if (rsp_id !== 2'd0) $display("FAIL async_rsp_id: got %0d want 0", rsp_id); else pass_cnt++;
        total_cnt++; if (mul_a !== 4'd0) $display("FAIL async_mul_a: got %0d want 0", mul_a); else pass_cnt++;
        total_cnt++; if (mul_b !== 4'd0) $display("FAIL async_mul_b: got %0d want 0", mul_b); else pass_cnt++;
        total_cnt++; if (req_ready !== 4'b0000) $display("FAIL async_req_ready: got %b want 0000", req_ready); else pass_cnt++;
        step();
        req_a[3:0] = 4'd1;
        req_b[3:0] = 4'd2;
        rst = 1'b0;
        #1;
        total_cnt++; if (req_ready !== 4'b0001) $display("FAIL post_rst_grant: got %b want 0001", req_ready); else pass_cnt++;
    endtask

    // All four valid, rsp_ready high: grants rotate 0,1,2,3,0.
    task automatic test_round_robin();
        logic [3:0] want;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            want = 4'b0001 << (g % 4);
            #1;
            total_cnt++; if (req_ready !== want) $display("FAIL rr_grant[%0d]: got %b want %b", g, req_ready, want); else pass_cnt++;
            step();
            repeat (LAT - 1) step();
            #1;
            total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL rr_valid[%0d]: got %b want 1", g, rsp_valid); else pass_cnt++;
            total_cnt++; if (rsp_id !== 2'(g % 4)) $display("FAIL rr_id[%0d]: got %0d want %0d", g, rsp_id, g % 4); else pass_cnt++;
            total_cnt++; if (rsp_prod !== prod_tab[g % 4]) $display("FAIL rr_prod[%0d]: got %h want %h", g, rsp_prod, prod_tab[g % 4]); else pass_cnt++;
            step();
        end
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        req_a     = {4'd9, 4'd15, 4'd3, 4'd1};
        req_b     = {4'd6, 4'd15, 4'd4, 4'd2};
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_reset_mid_resp();
        test_round_robin();
        step();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mult_share_arb.md
# mult_share_arb

Round-robin scheduler that shares one 4x4 combinational multiplier (`multiplier_4`: A, B in; C out) among NREQ requesters.
- Each requester submits an operand pair through a valid/ready handshake.
- The block drives the multiplier's A/B from registers and captures C.
- It returns the product tagged with the requester index on a single response port with backpressure.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 4, operand width; product width is 2W
- IDW, derived as ceil(log2(NREQ)), tag width
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  request i pending
- req_ready  out  NREQ  one-hot grant; handshake completes when req_valid[i] & req_ready[i]
- req_a  in  NREQ*W  operand A of requester i at bits [i*W +: W]
- req_b  in  NREQ*W  operand B of requester i, same packing
- mul_a  out  W  registered operand to multiplier A
- mul_b  out  W  registered operand to multiplier B
- mul_c  in  2W  multiplier product C
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer ready
- rsp_id  out  IDW  index of the requester owning rsp_prod
- rsp_prod  out  2W  captured product

## Operation
- FSM states: IDLE, CAPT, RESP; the WAIT state exists only with the macro.
- IDLE:
  - Winner = first i with req_valid[i]=1, scanning ptr, ptr+1, … mod NREQ.
  - req_ready[winner]=1 combinationally; all other bits 0.
  - req_ready is all-zero outside IDLE, and in IDLE when no request is valid.
  - On a grant edge: mul_a/mul_b <= winner's operands, winner tag stored, ptr <= (winner+1) mod NREQ, state <= CAPT.
- CAPT: rsp_prod <= mul_c, rsp_id <= stored tag, rsp_valid <= 1, state <= RESP.
- RESP: all outputs hold stable while rsp_ready=0. On the edge with rsp_ready=1: rsp_valid <= 0, state <= IDLE.
- Field retention: rsp_prod, rsp_id, mul_a and mul_b keep their last values after the response handshake.
- Arithmetic: mul_c is taken as the full 2W-bit product, without modification or checking.
- Wrap-around: a grant to NREQ-1 sets ptr to 0.
- Requester rules:
  - A requester may drop req_valid before being granted; no grant results and no state changes.
  - A granted requester may re-assert on the next cycle. It competes at lowest priority because ptr has moved past it.
- Reset (asynchronous, including mid-operation):
  - state=IDLE, ptr=0, mul_a=0, mul_b=0, rsp_valid=0, rsp_id=0, rsp_prod=0.
  - An accepted but unreturned operation is discarded with no notification.

## Timing
- Accept in cycle N → mul_a/mul_b valid in N+1 → rsp_valid=1 in N+2.
- Multiplier combinational delay must fit within one clock.
- Response handshake in cycle M → IDLE in M+1 → earliest next accept in M+1.
- Maximum throughput: one product per 3 cycles (4 with the macro) when rsp_ready is held high.
- rsp_valid, rsp_id, rsp_prod and mul_a/mul_b are register outputs. req_ready is combinational from req_valid, ptr and state.

## Configuration
- MULT_SHARE_PIPE_EN defined:
  - Adds the WAIT state between IDLE and CAPT for a multiplier with a registered output.
  - mul_c is sampled two edges after the accept edge.
  - Accept-to-rsp_valid latency becomes 3 cycles.
- MULT_SHARE_PIPE_EN undefined: no WAIT state; latency is 2 cycles as specified above.

## Test plan
- Reset:
  - Assert rst asynchronously mid-cycle → all outputs 0 immediately, req_ready=0.
  - Release with req_valid=4'b0000 → req_ready stays 0.
- Single request:
  - req_valid=4'b0100, a=5, b=3 → req_ready=4'b0100 the same cycle.
  - Two cycles later: rsp_valid=1, rsp_id=2, rsp_prod=8'h0F.
- Fairness, wrap and backpressure:
  - All four requesters valid, rsp_ready=1 → grants in order 0,1,2,3,0, each product correct.
  - Wrap: with ptr=3 and req_valid=4'b1010 → grant 3, then 1.
  - Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_id, rsp_prod stable; req_ready=0 throughout.
- Reset mid-RESP: with rsp_valid=1, pulse rst → rsp_valid=0 at once. With all requesters valid afterwards, the first grant goes to requester 0.
- Pipelined variant (MULT_SHARE_PIPE_EN, registered multiplier model): a=15, b=15 → rsp_prod=8'hE1 three cycles after accept.
